// File: rtl/seq_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package seq_divider_pkg;

    // Divider control states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } div_state_e;

    // Capture-edge-to-out_valid latency for a non-zero divisor.
    function automatic int unsigned div_latency(input int unsigned bits);
        return bits + 1;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, restore on borrow.
module div_step #(
    parameter int unsigned Width = 8
) (
    input  logic [Width:0]   rem_i,
    input  logic             bit_i,
    input  logic [Width-1:0] divisor_i,
    output logic [Width:0]   rem_o,
    output logic             q_o
);

    logic [Width+1:0] shifted;
    logic [Width+1:0] trial;
    logic             borrow;

    // Extra top bit of the trial result acts as the sign of (shifted - divisor).
    always_comb begin
        shifted = {rem_i, bit_i};
        trial   = shifted - {2'b00, divisor_i};
        borrow  = trial[Width+1];
        q_o     = ~borrow;
        rem_o   = borrow ? shifted[Width:0] : trial[Width:0];
    end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per cycle, MSB first.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (truncating quotient,
// remainder carries the dividend's sign); the default build is unsigned only.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned bits = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [bits-1:0] dividend,
    input  logic [bits-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [bits-1:0] quotient,
    output logic [bits-1:0] remainder,
    output logic            div_by_zero
);

    localparam int unsigned      CntW    = $clog2(bits) + 1;
    localparam logic [CntW-1:0]  LastCnt = CntW'(bits - 1);

    div_state_e      state_q;
    logic [CntW-1:0] cnt_q;
    logic [bits:0]   rem_q;
    logic [bits-1:0] dvd_q;
    logic [bits-1:0] dvs_q;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [bits-1:0] quotient_q;
    logic [bits-1:0] remainder_q;
    logic            div_by_zero_q;

    logic [bits:0]   step_rem;
    logic            step_q;
    logic [bits-1:0] q_raw;
    logic [bits-1:0] dvd_in;
    logic [bits-1:0] dvs_in;
    logic [bits-1:0] q_fin;
    logic [bits-1:0] r_fin;

    div_step #(
        .Width (bits)
    ) u_div_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[bits-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // dvd_q doubles as the quotient accumulator: dividend bits leave at the top,
    // quotient bits enter at the bottom.
    assign q_raw = {dvd_q[bits-2:0], step_q};

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;

    // Divide magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
    assign dvd_in = dividend[bits-1] ? ('0 - dividend) : dividend;
    assign dvs_in = divisor[bits-1]  ? ('0 - divisor)  : divisor;

    // Latch result signs together with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (state_q == StIdle && in_valid) begin
            neg_quo_q <= dividend[bits-1] ^ divisor[bits-1];
            neg_rem_q <= dividend[bits-1];
        end
    end

    // Sign fix-up folded into the final step so latency is unchanged.
    assign q_fin = neg_quo_q ? ('0 - q_raw) : q_raw;
    assign r_fin = neg_rem_q ? ('0 - step_rem[bits-1:0]) : step_rem[bits-1:0];
`else
    assign dvd_in = dividend;
    assign dvs_in = divisor;
    assign q_fin  = q_raw;
    assign r_fin  = step_rem[bits-1:0];
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            rem_q         <= '0;
            dvd_q         <= '0;
            dvs_q         <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (divisor == '0) begin
                            // Divide by zero resolves immediately without iterating.
                            quotient_q    <= '1;
                            remainder_q   <= dividend;
                            div_by_zero_q <= 1'b1;
                            out_valid_q   <= 1'b1;
                            state_q       <= StDone;
                        end else begin
                            dvd_q   <= dvd_in;
                            dvs_q   <= dvs_in;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    rem_q <= step_rem;
                    dvd_q <= q_raw;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == LastCnt) begin
                        quotient_q    <= q_fin;
                        remainder_q   <= r_fin;
                        div_by_zero_q <= 1'b0;
                        out_valid_q   <= 1'b1;
                        cnt_q         <= '0;
                        state_q       <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks for seq_divider (8-bit and 16-bit instances).
// Honours SEQ_DIVIDER_SIGNED_EN when the design is built with it.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, dbz8;
    logic [7:0] dividend8 = '0, divisor8 = '0, quotient8, remainder8;

    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, dbz16;
    logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;

`ifdef SEQ_DIVIDER_SIGNED_EN
    // 200 is -56 as an 8-bit two's-complement value: -56 / 7 = -8 rem 0.
    localparam logic [7:0] Q200 = 8'hF8;
    localparam logic [7:0] R200 = 8'h00;
`else
    localparam logic [7:0] Q200 = 8'd28;
    localparam logic [7:0] R200 = 8'd4;
`endif

    seq_divider #(.bits(8)) dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .dividend    (dividend8),
        .divisor     (divisor8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .quotient    (quotient8),
        .remainder   (remainder8),
        .div_by_zero (dbz8)
    );

    seq_divider #(.bits(16)) dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid16),
        .in_ready    (in_ready16),
        .dividend    (dividend16),
        .divisor     (divisor16),
        .out_valid   (out_valid16),
        .out_ready   (out_ready16),
        .quotient    (quotient16),
        .remainder   (remainder16),
        .div_by_zero (dbz16)
    );

    // Present operands and return #1 after the capture edge.
    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        dividend8 = a;
        divisor8  = b;
        in_valid8 = 1'b1;
        while (!in_ready8 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic start16(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        dividend16 = a;
        divisor16  = b;
        in_valid16 = 1'b1;
        while (!in_ready16 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid16 = 1'b0;
    endtask

    // Count edges (capture edge included) until out_valid is seen; bounded.
    task automatic wait8(input int start, output int lat);
        lat = start;
        while (!out_valid8 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", in_ready8); end
        checks++; if (out_valid8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid8); end
        checks++; if (quotient8 !== 8'd0) begin errors++; $display("FAIL reset_quotient got %0d want 0", quotient8); end
        checks++; if (remainder8 !== 8'd0) begin errors++; $display("FAIL reset_remainder got %0d want 0", remainder8); end
        checks++; if (dbz8 !== 1'b0) begin errors++; $display("FAIL reset_dbz got %0b want 0", dbz8); end
        checks++; if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0) begin
            errors++; $display("FAIL reset16_handshake got rdy=%0b vld=%0b want 1 0", in_ready16, out_valid16);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat;
        out_ready8 = 1'b1;
        start8(8'd200, 8'd7);
        // Operand churn and in_valid during BUSY must be ignored.
        dividend8 = 8'd255;
        divisor8  = 8'd1;
        in_valid8 = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        in_valid8 = 1'b0;
        wait8(4, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
        checks++; if (quotient8 !== Q200) begin errors++; $display("FAIL basic_quotient got %0d want %0d", quotient8, Q200); end
        checks++; if (remainder8 !== R200) begin errors++; $display("FAIL basic_remainder got %0d want %0d", remainder8, R200); end
        checks++; if (dbz8 !== 1'b0) begin errors++; $display("FAIL basic_dbz got %0b want 0", dbz8); end
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++; $display("FAIL basic_release got vld=%0b rdy=%0b want 0 1", out_valid8, in_ready8);
        end
    endtask

    task automatic test_div_zero;
        int lat;
        out_ready8 = 1'b1;
        start8(8'd55, 8'd0);
        wait8(1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency got %0d want 1", lat); end
        checks++; if (quotient8 !== 8'hFF) begin errors++; $display("FAIL dz_quotient got %0d want 255", quotient8); end
        checks++; if (remainder8 !== 8'd55) begin errors++; $display("FAIL dz_remainder got %0d want 55", remainder8); end
        checks++; if (dbz8 !== 1'b1) begin errors++; $display("FAIL dz_flag got %0b want 1", dbz8); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int lat;
        logic seen;
        out_ready8 = 1'b1;
        start8(8'd200, 8'd7);
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin
            errors++; $display("FAIL rstmid_handshake got rdy=%0b vld=%0b want 1 0", in_ready8, out_valid8);
        end
        checks++; if (quotient8 !== 8'd0 || remainder8 !== 8'd0 || dbz8 !== 1'b0) begin
            errors++; $display("FAIL rstmid_result got q=%0d r=%0d dz=%0b want 0 0 0", quotient8, remainder8, dbz8);
        end
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid8) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_abandon got out_valid=1 want 0"); end
        start8(8'd9, 8'd3);
        wait8(1, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL rstmid_latency got %0d want 9", lat); end
        checks++; if (quotient8 !== 8'd3 || remainder8 !== 8'd0) begin
            errors++; $display("FAIL rstmid_9div3 got q=%0d r=%0d want 3 0", quotient8, remainder8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold;
        int lat;
        out_ready8 = 1'b0;
        start8(8'd200, 8'd7);
        wait8(1, lat);
        checks++; if (lat !== 9) begin errors++; $display("FAIL hold_latency got %0d want 9", lat); end
        repeat (5) begin
            @(posedge clk); #1;
            checks++; if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0) begin
                errors++; $display("FAIL hold_handshake got vld=%0b rdy=%0b want 1 0", out_valid8, in_ready8);
            end
            checks++; if (quotient8 !== Q200 || remainder8 !== R200) begin
                errors++; $display("FAIL hold_result got q=%0d r=%0d want %0d %0d", quotient8, remainder8, Q200, R200);
            end
        end
        // Offer new operands during DONE; only the IDLE cycle may take them.
        out_ready8 = 1'b1;
        dividend8  = 8'd9;
        divisor8   = 8'd3;
        in_valid8  = 1'b1;
        @(posedge clk); #1;
        checks++; if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1) begin
            errors++; $display("FAIL hold_idle got vld=%0b rdy=%0b want 0 1", out_valid8, in_ready8);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        checks++; if (in_ready8 !== 1'b0) begin errors++; $display("FAIL hold_recapture got rdy=%0b want 0", in_ready8); end
        wait8(1, lat);
        checks++; if (lat !== 9 || quotient8 !== 8'd3 || remainder8 !== 8'd0) begin
            errors++; $display("FAIL hold_next got lat=%0d q=%0d r=%0d want 9 3 0", lat, quotient8, remainder8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random16;
        logic [15:0] a, b, eq, er;
        logic        done;
`ifdef SEQ_DIVIDER_SIGNED_EN
        logic signed [15:0] sa, sb;
`endif
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            if (i % 50 == 0) b = 16'd0;
            else if (i % 3 == 0) b = 16'($urandom_range(1, 15));
            else b = 16'($urandom);
            if (b == 16'd0) begin
                eq = 16'hFFFF;
                er = a;
            end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                sa = a;
                sb = b;
                if (a == 16'h8000 && b == 16'hFFFF) begin
                    eq = 16'h8000;
                    er = 16'd0;
                end else begin
                    eq = sa / sb;
                    er = sa % sb;
                end
`else
                eq = a / b;
                er = a % b;
`endif
            end
            start16(a, b);
            done = 1'b0;
            for (int n = 0; n < 200 && !done; n++) begin
                out_ready16 = 1'($urandom_range(0, 1));
                if (out_valid16 && out_ready16) begin
                    done = 1'b1;
                    checks++; if (quotient16 !== eq || remainder16 !== er || dbz16 !== (b == 16'd0)) begin
                        errors++;
                        $display("FAIL rand16 %0d/%0d got q=%0d r=%0d dz=%0b want q=%0d r=%0d", a, b,
                                 quotient16, remainder16, dbz16, eq, er);
                    end
                end
                @(posedge clk); #1;
            end
            if (!done) begin
                checks++; errors++;
                $display("FAIL rand16_timeout %0d/%0d got no result want one", a, b);
            end
        end
        out_ready16 = 1'b0;
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed;
        int lat;
        out_ready8 = 1'b1;
        start8(8'hF9, 8'h02);
        wait8(1, lat);
        checks++; if (quotient8 !== 8'hFD || remainder8 !== 8'hFF || dbz8 !== 1'b0) begin
            errors++; $display("FAIL signed_m7div2 got q=%0h r=%0h want fd ff", quotient8, remainder8);
        end
        @(posedge clk); #1;
        start8(8'h80, 8'hFF);
        wait8(1, lat);
        checks++; if (lat !== 9 || quotient8 !== 8'h80 || remainder8 !== 8'h00) begin
            errors++; $display("FAIL signed_min_div_m1 got lat=%0d q=%0h r=%0h want 9 80 00", lat, quotient8, remainder8);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_reset_mid();
        test_hold();
        test_random16();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter bits, default 64, giving the operand width in bits (legal range 4..128).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port dividend, input, bits wide: numerator.
REQ-007 The block SHALL have port divisor, input, bits wide: denominator.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result present.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port quotient, output, bits wide: result quotient.
REQ-011 The block SHALL have port remainder, output, bits wide: result remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: flags that the result came from divisor == 0.

Function
REQ-013 The block SHALL implement states IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE and out_valid SHALL be 1 only in DONE.
REQ-014 Operands SHALL be captured on the cycle in which in_valid && in_ready; capture SHALL go IDLE->BUSY, or IDLE->DONE if divisor == 0.
REQ-015 BUSY SHALL perform unsigned restoring division, one quotient bit per cycle, MSB first, using a (bits+1)-wide partial remainder.
REQ-016 Each BUSY step SHALL shift the partial remainder left by one, shifting in the next dividend bit; it SHALL then subtract the divisor if the result is non-negative, and record the quotient bit.
REQ-017 BUSY SHALL last exactly bits cycles, counted by a step counter of width clog2(bits)+1; on the last step the block SHALL go BUSY->DONE.
REQ-018 Latency from the capture edge to out_valid=1 SHALL be bits+1 cycles for a non-zero divisor and 1 cycle for divisor == 0.
REQ-019 For divisor == 0 the result SHALL be quotient all ones, remainder = dividend, div_by_zero = 1; otherwise div_by_zero SHALL be 0.
REQ-020 quotient, remainder and div_by_zero SHALL be registered and SHALL be held stable while out_valid && !out_ready.
REQ-021 The block SHALL go DONE->IDLE on out_valid && out_ready; the next operands SHALL be accepted no earlier than the following cycle.
REQ-022 in_valid and operand values SHALL be ignored outside IDLE; changing operands in BUSY SHALL NOT affect the result.
REQ-023 The result SHALL satisfy dividend == quotient*divisor + remainder with remainder < divisor, for all unsigned non-zero divisors.

Reset
REQ-024 rst=1 SHALL force state IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and step counter 0 on the next clk edge.
REQ-025 rst asserted in BUSY or DONE SHALL abandon the operation with no result produced; the first capture after rst is released SHALL compute correctly.

Configuration
REQ-026 Macro SEQ_DIVIDER_SIGNED_EN, when defined, SHALL treat operands as two's complement.
REQ-027 In signed mode, magnitudes SHALL be divided unsigned; the quotient SHALL truncate toward zero and the remainder SHALL take the dividend's sign.
REQ-028 In signed mode the sign fix-up SHALL be applied on the BUSY->DONE edge, with latency unchanged.
REQ-029 In signed mode, MIN/-1 SHALL return quotient = MIN and remainder = 0; divide by zero SHALL return quotient = -1 and remainder = dividend.
REQ-030 Without the macro, the block SHALL be unsigned only and SHALL contain no sign logic.

Structure
REQ-031 Package seq_divider_pkg SHALL hold the state typedef (IDLE/BUSY/DONE) and a function returning the latency for a given bits.
REQ-032 One combinational sub-module div_step SHALL implement the shift, trial subtract, restore and quotient-bit logic; it SHALL be instantiated once.

Verification (bits=8 unless noted)
REQ-033 Dividend 200, divisor 7 -> out_valid 9 cycles after capture; quotient 28, remainder 4, div_by_zero 0.
REQ-034 Dividend 55, divisor 0 -> out_valid 1 cycle after capture; quotient 255, remainder 55, div_by_zero 1.
REQ-035 Result held with out_ready=0 for 5 cycles -> outputs stable and in_ready=0; on the out_ready=1 cycle, IDLE follows and a new capture is accepted next cycle.
REQ-036 rst pulsed at BUSY step 4 -> all outputs at reset values; then 9/3 -> quotient 3, remainder 0.
REQ-037 bits=16, 1000 random operand pairs with random out_ready stalls -> every result satisfies REQ-023.
REQ-038 With SEQ_DIVIDER_SIGNED_EN: -7/2 -> quotient -3, remainder -1; -128/-1 -> quotient -128, remainder 0.
